// File: rtl/tapa_stream_pkg.sv
// Shared stream conventions: EOT sits at the MSB of each data word, and the
// packed width of an upsized stream is derived from the narrow width and ratio.
package tapa_stream_pkg;

    // Bit index of the EOT flag in a word that carries payload_width payload bits.
    function automatic int eot_pos(input int payload_width);
        return payload_width;
    endfunction

    function automatic int upsize_width(input int in_width, input int ratio);
        return in_width * ratio;
    endfunction

endpackage

// File: rtl/stream_upsizer_acc.sv
// Lane accumulator and lane counter for stream_upsizer. It exposes the packed
// word including the current input lane, so the top can load it on the closing word.
module stream_upsizer_acc
    import tapa_stream_pkg::*;
#(
    parameter int IN_WIDTH = 32,
    parameter int RATIO    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         accept,
    input  logic                         clear,
    input  logic [IN_WIDTH-1:0]          din,
    input  logic                         eot,
    output logic                         closing,
    output logic [IN_WIDTH*RATIO-1:0]    packed_word,
    output logic                         active
);

    localparam int CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    logic [RATIO-1:0][IN_WIDTH-1:0] acc;
    logic [RATIO-1:0][IN_WIDTH-1:0] lanes;
    logic [CNT_W-1:0]               cnt;

`ifdef STREAM_UPSIZER_EOT_EN
    assign closing = (cnt == LAST_LANE) | eot;
`else
    logic unused_eot;
    assign unused_eot = eot;
    assign closing    = (cnt == LAST_LANE);
`endif

    // Upper lanes are already zero here because acc is cleared on every close.
    always_comb begin
        lanes = acc;
        for (int i = 0; i < RATIO; i++) begin
            if (CNT_W'(i) == cnt) lanes[i] = din;
        end
    end

    assign packed_word = lanes;
    assign active      = (cnt != '0);

    // NOTE: acc is a handful of flops, not a RAM, so resetting it is cheap and
    // guarantees a partially packed word never leaks into the next output.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc[cnt] <= din;
            cnt      <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/stream_upsizer.sv
// Width-up converter between FWFT stream stages: packs RATIO narrow words into
// one wide word. Optional early close on EOT via macro STREAM_UPSIZER_EOT_EN.
module stream_upsizer
    import tapa_stream_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO     = 4,
    parameter int OUT_WIDTH = upsize_width(IN_WIDTH, RATIO)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_empty_n,
    output logic                 in_read,
    input  logic [IN_WIDTH:0]    in_dout,
    input  logic                 out_full_n,
    output logic                 out_write,
    output logic [OUT_WIDTH:0]   out_din,
    output logic                 busy
);

    localparam int IN_EOT = eot_pos(IN_WIDTH);

    logic                 closing_word;
    logic                 acc_fire;
    logic                 close_fire;
    logic                 out_fire;
    logic                 acc_active;
    logic                 eot_flag;
    logic [OUT_WIDTH-1:0] packed_word;
    logic [OUT_WIDTH:0]   out_q;
    logic                 out_valid;

`ifdef STREAM_UPSIZER_EOT_EN
    assign eot_flag = in_dout[IN_EOT];
`else
    assign eot_flag = 1'b0;
`endif

    stream_upsizer_acc #(
        .IN_WIDTH (IN_WIDTH),
        .RATIO    (RATIO)
    ) u_acc (
        .clk         (clk),
        .reset       (reset),
        .accept      (acc_fire),
        .clear       (close_fire),
        .din         (in_dout[IN_WIDTH-1:0]),
        .eot         (in_dout[IN_EOT]),
        .closing     (closing_word),
        .packed_word (packed_word),
        .active      (acc_active)
    );

    // Only a closing word needs the output slot; it may land in the same cycle
    // the slot drains, which is what keeps word boundaries bubble-free.
    assign in_read    = !reset & in_empty_n & (!closing_word | !out_valid | out_full_n);
    assign acc_fire   = in_empty_n & in_read;
    assign close_fire = acc_fire & closing_word;
    assign out_fire   = out_valid & out_full_n;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the handshake terms above are all combinational.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (close_fire) begin
            out_q     <= {eot_flag, packed_word};
            out_valid <= 1'b1;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    assign out_write = out_valid;
    assign out_din   = out_q;
    assign busy      = !reset & (acc_active | out_valid);

endmodule
